// File: rtl/as_imem_scan_loader.sv
// rtl/as_imem_scan_loader.sv - JTAG-fed instruction memory loader; optional readback via AS_IMSCAN_READBACK_EN
`timescale 1ns/1ps
module as_imem_scan_loader #(
    parameter int IMEM_ADDR_W = 10,
    parameter int INSTR_W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   tck_i,
    input  logic                   tdi_i,
    input  logic                   sel_i,
    input  logic                   capture_dr_i,
    input  logic                   shift_dr_i,
    input  logic                   update_dr_i,
    output logic                   tdo_o,
    output logic                   imem_req_o,
    output logic [IMEM_ADDR_W-1:0] imem_addr_o,
    output logic [INSTR_W-1:0]     imem_wdata_o,
    output logic                   imem_we_o,
    input  logic                   imem_gnt_i,
    input  logic [INSTR_W-1:0]     imem_rdata_i,
    output logic                   loading_o,
    output logic [15:0]            wr_cnt_o,
    output logic                   ovf_o,
    output logic                   err_o
);
    localparam int SCAN_LEN = IMEM_ADDR_W + INSTR_W + 1;

`ifdef AS_IMSCAN_READBACK_EN
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_WRITE} state_t;
`endif

    state_t                state;
    logic [SCAN_LEN-1:0]   sr;
    logic [5:0]            sync_a;
    logic [5:0]            sync_b;
    logic                  tck_d;

    // All TCK-domain signals share one synchronizer depth so flags line up with the tck edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_a <= '0;
            sync_b <= '0;
            tck_d  <= 1'b0;
        end else begin
            sync_a <= {tck_i, tdi_i, sel_i, capture_dr_i, shift_dr_i, update_dr_i};
            sync_b <= sync_a;
            tck_d  <= sync_b[5];
        end
    end

    logic tck_rise;
    logic do_capture;
    logic do_shift;
    logic do_update;
    assign tck_rise   = sync_b[5] & ~tck_d;
    assign do_capture = tck_rise & sync_b[3] & sync_b[2];
    assign do_shift   = tck_rise & sync_b[3] & sync_b[1] & ~sync_b[2];
    assign do_update  = tck_rise & sync_b[3] & sync_b[0] & ~sync_b[2] & ~sync_b[1];

    logic [IMEM_ADDR_W-1:0] upd_addr;
    logic [INSTR_W-1:0]     upd_data;
    logic                   upd_we;
    assign upd_addr = sr[SCAN_LEN-1 -: IMEM_ADDR_W];
    assign upd_data = sr[INSTR_W:1];
    assign upd_we   = sr[0];
    assign tdo_o    = sr[SCAN_LEN-1];

`ifdef AS_IMSCAN_READBACK_EN
    logic [INSTR_W-1:0] rb_data;
    logic               rb_valid;
`else
    logic unused_rdata;
    assign unused_rdata = ^imem_rdata_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            sr           <= '0;
            imem_req_o   <= 1'b0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
            wr_cnt_o     <= '0;
            ovf_o        <= 1'b0;
            err_o        <= 1'b0;
            loading_o    <= 1'b1;
`ifdef AS_IMSCAN_READBACK_EN
            rb_data      <= '0;
            rb_valid     <= 1'b0;
`endif
        end else begin
            // Scan register keeps working while a request is outstanding.
            if (do_capture) begin
`ifdef AS_IMSCAN_READBACK_EN
                sr       <= {upd_addr, (rb_valid ? rb_data : {INSTR_W{1'b0}}), 1'b0};
                rb_valid <= 1'b0;
`else
                sr <= {upd_addr, {INSTR_W{1'b0}}, 1'b0};
`endif
            end else if (do_shift) begin
                sr <= {sr[SCAN_LEN-2:0], sync_b[4]};
            end

            case (state)
                S_IDLE: begin
                    if (do_update) begin
                        if (upd_we) begin
                            if (upd_addr[1:0] == 2'b00) begin
                                imem_addr_o  <= upd_addr;
                                imem_wdata_o <= upd_data;
                                imem_we_o    <= 1'b1;
                                imem_req_o   <= 1'b1;
                                loading_o    <= 1'b1;
                                state        <= S_WRITE;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else begin
                            loading_o <= 1'b0;
`ifdef AS_IMSCAN_READBACK_EN
                            imem_addr_o <= upd_addr;
                            imem_we_o   <= 1'b0;
                            imem_req_o  <= 1'b1;
                            rb_valid    <= 1'b0;
                            state       <= S_READ;
`endif
                        end
                    end
                end
                S_WRITE: begin
                    if (do_update) begin
                        ovf_o <= 1'b1;
                    end
                    if (imem_gnt_i) begin
                        imem_req_o <= 1'b0;
                        imem_we_o  <= 1'b0;
                        if (wr_cnt_o != 16'hFFFF) begin
                            wr_cnt_o <= wr_cnt_o + 16'd1;
                        end
                        state <= S_IDLE;
                    end
                end
`ifdef AS_IMSCAN_READBACK_EN
                S_READ: begin
                    if (do_update) begin
                        ovf_o <= 1'b1;
                    end
                    // Stay one extra cycle after the grant to catch the read data.
                    if (imem_req_o) begin
                        if (imem_gnt_i) begin
                            imem_req_o <= 1'b0;
                        end
                    end else begin
                        rb_data  <= imem_rdata_i;
                        rb_valid <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: doc/as_imem_scan_loader.md
AS_IMEM_SCAN_LOADER -- requirements
Module: as_imem_scan_loader

Interface
REQ-001 Parameter IMEM_ADDR_W, default 10, byte-address width of the instruction memory.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter SCAN_LEN, fixed to IMEM_ADDR_W+INSTR_W+1 (43 by default); scan word = {addr, data, we}, we at bit 0.
REQ-004 clk_i  in  1  system clock; the only clock.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 tck_i, tdi_i  in  1 each  raw JTAG clock and data, asynchronous to clk_i.
REQ-007 sel_i, capture_dr_i, shift_dr_i, update_dr_i  in  1 each  TAP IR-decode (IR=0x80) and DR-state flags, TCK domain.
REQ-008 tdo_o  out  1  scan chain MSB.
REQ-009 imem_req_o  out  1; imem_addr_o  out  IMEM_ADDR_W; imem_wdata_o  out  INSTR_W; imem_we_o  out  1  memory request.
REQ-010 imem_gnt_i  in  1  memory accepts the request in the cycle it is high.
REQ-011 imem_rdata_i  in  INSTR_W  read data, valid the cycle after a granted read (readback build only).
REQ-012 loading_o  out  1  image load in progress; drives core reset.
REQ-013 wr_cnt_o  out  16  completed writes, saturating at 0xFFFF.
REQ-014 ovf_o, err_o  out  1 each  sticky: update dropped while busy / misaligned address.

Function
REQ-015 tck_i, tdi_i and all TAP flags pass through 2-FF synchronizers; actions occur on a synchronized tck rising edge using synchronized flags; clk_i shall be at least 4x tck_i.
REQ-016 Edge with sel and capture_dr: scan register loads {current address field, 0, 0}, or readback data per REQ-029.
REQ-017 Edge with sel and shift_dr: scan register shifts left, tdi enters bit 0; tdo_o = bit SCAN_LEN-1; the first bit shifted ends at the MSB.
REQ-018 Edge with sel and update_dr: decode {addr, data, we} from the scan register.
REQ-019 FSM states IDLE, WRITE, READ (READ only in the readback build).
REQ-020 IDLE, update with we=1 and addr[1:0]=0: latch addr/data, imem_we_o=1, imem_req_o=1 the next cycle, go to WRITE; loading_o=1.
REQ-021 IDLE, update with we=1 and addr[1:0]!=0: no request; err_o set.
REQ-022 IDLE, update with we=0: loading_o=0 (image complete); no write.
REQ-023 WRITE: addr, data, we and req held stable until imem_gnt_i; in the grant cycle wr_cnt_o increments (saturating); req drops next cycle; return to IDLE.
REQ-024 Update in any state other than IDLE: update dropped, ovf_o set, FSM unaffected.
REQ-025 Shift or capture while in WRITE is permitted; only the latched request registers are frozen.
REQ-026 ovf_o and err_o clear only on reset.

Reset
REQ-027 rst_ni low asynchronously forces: FSM IDLE, scan register 0, synchronizers 0, imem_req_o=0, imem_we_o=0, imem_addr_o=0, imem_wdata_o=0, tdo_o=0, wr_cnt_o=0, ovf_o=0, err_o=0, loading_o=1.
REQ-028 Reset asserted mid-shift or mid-WRITE aborts the operation; no grant is counted after release.

Configuration
REQ-029 Macro AS_IMSCAN_READBACK_EN defined: an update with we=0 also issues a read (imem_we_o=0) at addr via READ; imem_rdata_i is latched one cycle after the grant; the next capture loads {addr, rdata, 0}.
REQ-030 Macro AS_IMSCAN_READBACK_EN undefined: no READ state; imem_we_o is always 1 when req=1; imem_rdata_i is ignored; capture loads data=0.

Verification
REQ-031 Shift {0x000, 0x00010137, 1}, gnt tied high -> one req cycle: addr=0x000, wdata=0x00010137; wr_cnt_o=1; loading_o=1.
REQ-032 Shift {0x3F0, 0xAAAAAAAA, 1}, gnt delayed 5 cycles -> req/addr/data stable for 6 cycles; wr_cnt_o +1 in the grant cycle only.
REQ-033 Second update arrives while gnt is held low -> ovf_o=1, first write completes unchanged, wr_cnt_o +1 only.
REQ-034 Shift {0x006, x, 1} -> no req, err_o=1; then shift {0x000, 0x4AAAAA88, 0} -> loading_o=0.
REQ-035 rst_ni pulsed low after 20 of 43 shift bits, or during WRITE -> all outputs take REQ-027 values immediately; a re-shifted word writes correctly.
REQ-036 (AS_IMSCAN_READBACK_EN) Write 0x5555_5555 to 0x004, update we=0 at 0x004, then capture and shift out -> tdo_o stream equals {0x004, 0x55555555, 0}, MSB first.
